mmio_uart_tx: RTL and testbench
===============================

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries, power of two.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0100, byte address of the DATA register.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, asynchronous, active-low reset.
REQ-006 Port we, input, 1, core store strobe, driven from the core's MemWrite.
REQ-007 Port addr, input, 32, core data address, driven from the core's ALUResult.
REQ-008 Port wdata, input, 32, core store data, driven from the core's RD2.
REQ-009 Port rdata, output, 32, combinational status read data.
REQ-010 Port tx, output, 1, registered serial line; idle level 1.

Function
REQ-011 The DATA register (addr==BASE_ADDR, we=1) SHALL push wdata[7:0] into the FIFO if the FIFO is not full at the start of that cycle.
REQ-012 A DATA write while the FIFO is full SHALL be dropped and SHALL set sticky STATUS.overflow.
REQ-013 The STATUS register (addr==BASE_ADDR+4) SHALL read as {24'b0, count[3:0], overflow, busy, empty, full} in bits [7:0]; rdata SHALL be 0 for every other address.
REQ-014 A write to STATUS SHALL clear overflow; the write data is ignored.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY (macro-gated), and STOP.
REQ-016 IDLE: when the FIFO is non-empty, the FSM SHALL pop one byte, enter START and drive tx=0 from the next edge.
REQ-017 Each state SHALL hold tx for exactly CLKS_PER_BIT cycles, counted by a baud counter that reloads on every state entry.
REQ-018 DATA SHALL send 8 bits LSB-first, using a 3-bit index that wraps from 7 into the next state.
REQ-019 STOP SHALL drive tx=1; on expiry it SHALL go to START with a pop if the FIFO is non-empty, so there is no idle gap, and otherwise to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; a push when count==FIFO_DEPTH-1 together with a pop SHALL be accepted.
REQ-022 Latency: for a DATA write sampled at edge E0 into an idle, empty block, tx SHALL go low after edge E1.

Reset
REQ-023 rst low SHALL immediately force state=IDLE, tx=1, FIFO empty, count=0, overflow=0, baud counter=0 and bit index=0, including mid-frame.
REQ-024 After reset release, STATUS SHALL read 32'h0000_0002.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, the frame SHALL carry an even-parity bit (XOR of the 8 data bits) in state PARITY between DATA and STOP, giving an 11-bit frame.
REQ-026 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP, giving a 10-bit frame.

Structure
REQ-027 A shared package/header uart_pkg SHALL hold the FSM state encodings, the register offsets DATA=0 and STATUS=4, and the STATUS bit indices.
REQ-028 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count).
REQ-029 The block SHALL sit downstream of the core's store path, decoded in parallel with Data_Memory, and SHALL be instantiated in the top.

Verification
REQ-030 With CLKS_PER_BIT=4, a write of 0x55 to DATA SHALL produce tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), after which busy=0.
REQ-031 Ten consecutive-cycle DATA writes of 0x00..0x09 SHALL result in 0x00..0x08 being transmitted back-to-back with no idle gap, 0x09 being dropped, and overflow=1; a subsequent write to STATUS SHALL read back overflow=0.
REQ-032 Asserting rst low during data bit 3 of 0xA5, with 2 bytes still queued, SHALL force tx=1 immediately, STATUS=0x02 after release, and no further frame.
REQ-033 A STATUS read after a single queued write while a frame is in flight SHALL return count=1, busy=1, empty=0, full=0 (32'h0000_0014); a read at BASE_ADDR+8 SHALL return 0.
REQ-034 With UART_TX_PARITY_EN and CLKS_PER_BIT=4, writing 0x07 SHALL produce data 1,1,1,0,0,0,0,0, parity bit 1, then stop bit 1 (44 cycles).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for mmio_uart_tx: FSM states, register offsets and STATUS bit positions.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uart_state_t;

    localparam logic [31:0] DATA_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int unsigned STAT_FULL    = 0;
    localparam int unsigned STAT_EMPTY   = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_OVF     = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two (>= 2).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA register feeds a FIFO, STATUS reports FIFO/line state.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          pop;
    logic          overflow;

    logic          data_wr;
    logic          stat_wr;
    logic          stat_rd;
    logic          baud_last;
    logic          busy;

    logic [7:0]                    fifo_dout;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [3:0]                    count4;
    logic                          unused_wdata;

    assign data_wr      = we && (addr == BASE_ADDR + DATA_OFS);
    assign stat_wr      = we && (addr == BASE_ADDR + STATUS_OFS);
    assign stat_rd      = (addr == BASE_ADDR + STATUS_OFS);
    assign baud_last    = (baud == BAUD_LAST);
    assign busy         = (state != S_IDLE);
    assign count4       = 4'(fifo_count);
    assign unused_wdata = ^wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud     <= '0;
            idx      <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            baud  <= baud_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
            if (stat_wr)                    overflow <= 1'b0;
            else if (data_wr && fifo_full)  overflow <= 1'b1;
        end
    end

    // tx_n is the level for the state being entered, so the line changes on the entry edge.
    always_comb begin
        state_n = state;
        baud_n  = baud + BW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_n = fifo_dout;
                    state_n = S_START;
                    tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = S_DATA;
                    tx_n    = shreg[0];
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    idx_n  = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        tx_n    = ^shreg;
`else
                        state_n = S_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        tx_n = shreg[idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_n = fifo_dout;
                        state_n = S_START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                baud_n  = '0;
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        if (stat_rd) begin
            rdata[STAT_FULL]            = fifo_full;
            rdata[STAT_EMPTY]           = fifo_empty;
            rdata[STAT_BUSY]            = busy;
            rdata[STAT_OVF]             = overflow;
            rdata[STAT_CNT_LSB +: 4]    = count4;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized self-checking bench for mmio_uart_tx against a queue-based line model.
// Honours UART_TX_PARITY_EN in the model's frame construction.
module tb_mmio_uart_tx;
    localparam int unsigned CPB    = 4;
    localparam int unsigned DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_NONE = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    int n_checks = 0;
    int n_fail   = 0;

    byte unsigned q[$];
    bit           bits[$];
    bit           m_ovf  = 1'b0;
    bit           m_busy = 1'b0;
    bit           m_tx   = 1'b1;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (a == A_STAT)
            return {24'b0, 4'(q.size()), m_ovf, m_busy, q.size() == 0, q.size() == DEPTH};
        return 32'h0;
    endfunction

    // Line model: once the previous frame's bits are exhausted, the next queued byte starts.
    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        bit           was_full;
        bit           was_empty;
        byte unsigned b;
        bit           fb[$];
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (bits.size() == 0) begin
            if (!was_empty) begin
                b = q.pop_front();
                fb.push_back(1'b0);
                for (int i = 0; i < 8; i++) fb.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                fb.push_back(^b);
`endif
                fb.push_back(1'b1);
                foreach (fb[k]) for (int r = 0; r < CPB; r++) bits.push_back(fb[k]);
                m_busy = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
        m_tx = (bits.size() > 0) ? bits.pop_front() : 1'b1;
        if (w && a == A_DATA) begin
            if (!was_full) q.push_back(d[7:0]);
            else           m_ovf = 1'b1;
        end
        if (w && a == A_STAT) m_ovf = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        bits.delete();
        m_ovf  = 1'b0;
        m_busy = 1'b0;
        m_tx   = 1'b1;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d;
        #1;
        check("rdata", rdata, exp_rdata(a));
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        check("tx", {31'b0, tx}, {31'b0, m_tx});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, A_STAT, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        we  = 1'b0;
        #1;
        check("rst_tx", {31'b0, tx}, 32'h1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        addr = A_STAT;
        #1;
        check("rst_status", rdata, 32'h0000_0002);
        @(negedge clk);
    endtask

    initial begin
        int r;
        @(negedge clk);
        do_reset();

        // single 0x55 frame, then idle
        step(1'b1, A_DATA, 32'hFFFF_FF55);
        idle(48);

        // ten back-to-back writes: one dropped, overflow sticks
        for (int i = 0; i < 10; i++) step(1'b1, A_DATA, 32'(i));
        addr = A_STAT;
        #1;
        check("ovf_set", {31'b0, rdata[3]}, 32'h1);
        idle(200);
        step(1'b1, A_STAT, 32'hFFFF_FFFF);
        addr = A_STAT;
        #1;
        check("ovf_clr", {31'b0, rdata[3]}, 32'h0);
        idle(260);

        // one byte in flight plus one queued
        step(1'b1, A_DATA, 32'h0000_003C);
        step(1'b1, A_DATA, 32'h0000_00C3);
        addr = A_STAT;
        #1;
        check("status_inflight", rdata, 32'h0000_0014);
        addr = A_NONE;
        #1;
        check("status_unmapped", rdata, 32'h0);
        idle(100);

        // reset during data bit 3 of 0xA5 with two bytes queued
        step(1'b1, A_DATA, 32'h0000_00A5);
        step(1'b1, A_DATA, 32'h0000_00B1);
        step(1'b1, A_DATA, 32'h0000_00C2);
        idle(16);
        check("pre_rst_tx_bit3", {31'b0, tx}, 32'h0);
        do_reset();
        idle(60);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: step(1'b1, A_DATA, $urandom);
                4:          step(1'b1, A_STAT, $urandom);
                5:          step(1'b0, A_NONE, $urandom);
                6:          step(1'b0, $urandom, $urandom);
                default:    step(1'b0, A_STAT, 32'h0);
            endcase
        end
        idle(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
